// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, framing constants and the parity helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 39;
    localparam int DATA_BITS            = 8;

    // Even parity holds when data bits plus parity bit contain an even number of ones.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to 1 (idle line level).
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and registered status pulses.
// Optional even-parity check compiled in with `define UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 o_Rx_Active,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] BIT_CNT  = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_e          state_r, state_n;
    logic [7:0]           clk_cnt_r, clk_cnt_n;
    logic [2:0]           bit_idx_r, bit_idx_n;
    logic [DATA_BITS-1:0] shreg_r, shreg_n;
    logic [DATA_BITS-1:0] dout_r, dout_n;
    logic                 done_r, done_n;
    logic                 ferr_r, ferr_n;
    logic                 perr_r, perr_n;
    logic                 active_r, active_n;
    logic                 rx_s;
    logic                 par_ok_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_r, par_n;
    assign par_ok_s = even_parity_ok(shreg_r, par_r);
`else
    assign par_ok_s = 1'b1;
`endif

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            clk_cnt_r <= 8'd0;
            bit_idx_r <= 3'd0;
            shreg_r   <= '0;
            dout_r    <= '0;
            done_r    <= 1'b0;
            ferr_r    <= 1'b0;
            perr_r    <= 1'b0;
            active_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_n;
            clk_cnt_r <= clk_cnt_n;
            bit_idx_r <= bit_idx_n;
            shreg_r   <= shreg_n;
            dout_r    <= dout_n;
            done_r    <= done_n;
            ferr_r    <= ferr_n;
            perr_r    <= perr_n;
            active_r  <= active_n;
`ifdef UART_RX_PARITY_EN
            par_r     <= par_n;
`endif
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_n   = state_r;
        clk_cnt_n = clk_cnt_r;
        bit_idx_n = bit_idx_r;
        shreg_n   = shreg_r;
        dout_n    = dout_r;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
        active_n  = active_r;
`ifdef UART_RX_PARITY_EN
        par_n     = par_r;
`endif
        case (state_r)
            S_IDLE: begin
                clk_cnt_n = 8'd0;
                bit_idx_n = 3'd0;
                if (!rx_s) begin
                    state_n  = S_START;
                    active_n = 1'b1;
                end else begin
                    active_n = 1'b0;
                end
            end
            S_START: begin
                if (clk_cnt_r == HALF_CNT) begin
                    clk_cnt_n = 8'd0;
                    if (!rx_s) begin
                        state_n = S_DATA;
                    end else begin
                        state_n  = S_IDLE;
                        active_n = 1'b0;
                    end
                end else begin
                    clk_cnt_n = clk_cnt_r + 8'd1;
                end
            end
            S_DATA: begin
                if (clk_cnt_r == BIT_CNT) begin
                    clk_cnt_n          = 8'd0;
                    shreg_n[bit_idx_r] = rx_s;
                    if (bit_idx_r == LAST_IDX) begin
                        bit_idx_n = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_n   = S_PARITY;
`else
                        state_n   = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt_r + 8'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_r == BIT_CNT) begin
                    clk_cnt_n = 8'd0;
                    par_n     = rx_s;
                    state_n   = S_STOP;
                end else begin
                    clk_cnt_n = clk_cnt_r + 8'd1;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt_r == BIT_CNT) begin
                    clk_cnt_n = 8'd0;
                    perr_n    = ~par_ok_s;
                    if (rx_s) begin
                        dout_n   = shreg_r;
                        done_n   = par_ok_s;
                        state_n  = S_IDLE;
                        active_n = 1'b0;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_n = clk_cnt_r + 8'd1;
                end
            end
            // A held-low line (break) must not be mistaken for a new start bit.
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_n  = S_IDLE;
                    active_n = 1'b0;
                end else begin
                    state_n = S_WAIT_HIGH;
                end
            end
            default: begin
                state_n  = S_IDLE;
                active_n = 1'b0;
            end
        endcase
    end

    assign dout         = dout_r;
    assign rx_done_tick = done_r;
    assign frame_err    = ferr_r;
    assign o_Rx_Active  = active_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_r;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver: 8N1 framing, LSB first, idle-high line.
- Counterpart to the UART transmitter in the UARTComp path. Recovers bytes from the Rx pin and hands them to the receive FIFO or consumer with a one-cycle done tick.
- Oversamples with a per-bit clock counter. Samples each bit at mid-bit.

Parameters:
- CLKS_PER_BIT, 39, clk cycles per bit period. Legal range 4..255; the counter is 8 bits.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- dout  output  8  last received byte. Valid when rx_done_tick=1; held until the next frame completes.
- rx_done_tick  output  1  one-cycle pulse: valid frame received.
- o_Rx_Active  output  1  high from start-bit detection until return to IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch. Constant 0 when UART_RX_PARITY_EN is undefined.

Behaviour:
- Reset (async, active-high):
  - State forced to S_IDLE; counters and the shift register cleared.
  - dout=0x00; rx_done_tick, frame_err, parity_err and o_Rx_Active all 0.
  - Both synchronizer flops set to 1 (line idle).
  - Reset mid-frame aborts the frame: no tick, no error pulse.
- rx passes through a 2-FF synchronizer. The FSM uses only the synchronized rx_s, which gives 2 cycles of fixed latency.
- S_IDLE:
  - clk_cnt=0, bit_idx=0.
  - If rx_s==0, go to S_START and set o_Rx_Active=1.
- S_START:
  - Count clk_cnt up to (CLKS_PER_BIT-1)/2 (integer division; 19 at default).
  - At that count, if rx_s==0: clk_cnt=0, go to S_DATA.
  - Otherwise it is a false start (glitch): go to S_IDLE, o_Rx_Active=0, no pulses.
- S_DATA:
  - Count to CLKS_PER_BIT-1. At that count: clk_cnt=0, shift rx_s into shreg[bit_idx].
  - After bit_idx 7: bit_idx=0, next state S_STOP (or S_PARITY when the feature is enabled).
  - All samples therefore fall at mid-bit.
- S_STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - Sample is 1: dout<=shreg; rx_done_tick=1 for exactly one cycle; go to S_IDLE, o_Rx_Active=0.
  - Sample is 0: frame_err=1 for one cycle; dout not updated; go to S_WAIT_HIGH.
- S_WAIT_HIGH:
  - Stay until rx_s==1, then go to S_IDLE and set o_Rx_Active=0.
  - This prevents a break condition from re-triggering as a start bit.
- Timing:
  - The done tick lands 9.5 bit periods after the start edge (≈ 9*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 + 3 cycles).
  - Back-to-back frames are accepted: IDLE is re-entered mid-stop-bit, so the next start edge is caught with up to ½ bit of margin.
- Simultaneous events: rx_done_tick and frame_err are never high together. A tick and a new start detection cannot occur in the same cycle.
- Unused state encodings return to S_IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state S_PARITY between S_DATA and S_STOP: one bit period, sampled at mid-bit.
  - Even parity check: if XOR(shreg, parity_sample) != 0, pulse parity_err for one cycle, coincident with the stop-bit decision.
  - rx_done_tick is suppressed when parity_err fires. dout is still updated.
- Undefined:
  - 8N1 only; the S_PARITY state logic is not compiled.
  - parity_err tied to 0.

Decomposition:
- uart_pkg holds:
  - state encodings S_IDLE=3'd0, S_START=3'd1, S_DATA=3'd2, S_PARITY=3'd3, S_STOP=3'd4, S_WAIT_HIGH=3'd5;
  - default CLKS_PER_BIT=39;
  - DATA_BITS=8.
- The transmitter shares this package.
- One sub-module: uart_sync2 (2-FF synchronizer, reset value 1), reused for other async inputs.

Test Plan:
- Drive byte 0xA5 (8N1, CLKS_PER_BIT=39, LSB first) -> dout=0xA5, rx_done_tick high exactly 1 cycle, frame_err=0, o_Rx_Active low after tick.
- Back-to-back frames 0x00 then 0xFF, no idle gap -> two ticks with dout=0x00 then 0xFF, spaced 10*39 cycles ±2.
- Pulse rx low for 10 cycles, then high -> no tick, no frame_err, FSM back in S_IDLE, o_Rx_Active low within 22 cycles.
- Frame 0x3C with stop bit driven 0 and line held low 100 more cycles -> frame_err 1-cycle pulse, no tick, dout unchanged, no new frame until line returns high.
- Assert reset during bit 4 of 0x81, release, then send 0x42 -> only one tick, dout=0x42.
- UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> tick, dout=0x07; send 0x07 with parity bit 0 -> parity_err pulse, no tick.
